storage_reader: RTL

STORAGE_READER -- requirements
Module: storage_reader

---
 rtl/storage_reader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/storage_reader.sv
// Purpose: walks a single word or a burst of consecutive addresses out of a synchronous-read storage.
// Latency: Mem_Rd is high in the cycle after Req is sampled; the word is first presented for acceptance two edges later.
// Backpressure: Data_Output/Out_Valid hold indefinitely until Out_Ready; no new read is issued until the held word is taken.
module storage_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Req,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] Start_Addr,
  input  logic [ADDR_W:0]   Length,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Rd,
  input  logic [DATA_W-1:0] Mem_Data,
  output logic [DATA_W-1:0] Data_Output,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   Word_Count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Count constants: one word, and a full sweep of the storage (what Length=0 means).
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining;

  logic [ADDR_W:0]   load_count;
  logic [ADDR_W-1:0] addr_next;
  logic              handshake;

  // Number of words a newly accepted request will transfer.
  always_comb begin
    load_count = CNT_ONE;
    if (Mode) begin
      load_count = (Length == '0) ? CNT_FULL : Length;
    end
  end

  // Address increments wrap naturally at the storage size.
  assign addr_next = addr_q + ADDR_ONE;
  assign handshake = (state == OUT) && Out_Ready;

  // Request sequencing: accept, issue one read, capture the word, hold it until accepted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      addr_q      <= '0;
      remaining   <= '0;
      Mem_Addr    <= '0;
      Mem_Rd      <= 1'b0;
      Data_Output <= '0;
      Out_Valid   <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Word_Count  <= '0;
    end else begin
      // Both strobes are single-cycle unless re-armed below.
      Done   <= 1'b0;
      Mem_Rd <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            addr_q     <= Start_Addr;
            Mem_Addr   <= Start_Addr;
            remaining  <= load_count;
            Word_Count <= '0;
            Mem_Rd     <= 1'b1;
            Busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // Storage data is valid in this cycle, one cycle after the read strobe.
          Data_Output <= Mem_Data;
          Out_Valid   <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (handshake) begin
            Out_Valid  <= 1'b0;
            Word_Count <= Word_Count + CNT_ONE;
            remaining  <= remaining - CNT_ONE;
            addr_q     <= addr_next;
            if (remaining > CNT_ONE) begin
              // Mem_Addr only moves when a new read is launched, so it holds after the last word.
              Mem_Addr <= addr_next;
              Mem_Rd   <= 1'b1;
              state    <= ISSUE;
            end else begin
              Busy  <= 1'b0;
              Done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Done marks completion after the final word has left, so it never overlaps a presented word.
  a_done_not_valid: assert property (@(posedge CLK) disable iff (RST) Done |-> !Out_Valid);

  // The read strobe belongs to the issue cycle only.
  a_rd_in_issue: assert property (@(posedge CLK) disable iff (RST) Mem_Rd |-> (state == ISSUE));

  // A presented word must not change while it waits for the consumer.
  a_hold_stable: assert property (@(posedge CLK) disable iff (RST)
    (Out_Valid && !Out_Ready) |=> (Out_Valid && $stable(Data_Output)));

endmodule
